// File: rtl/pipeline_ctrl.sv
// Pipeline sequencer: merges stage stall requests, issues one-cycle flushes on exceptions/ERET,
// and breaks persistent stalls with a watchdog. Perf counters are built only with PIPE_PERF_CNT_EN.
module pipeline_ctrl #(
  parameter logic [31:0] EXC_BASE      = 32'h0000_0100,
  parameter logic [31:0] WDT_VECTOR    = 32'h0000_0120,
  parameter logic [15:0] STALL_TIMEOUT = 16'd1024
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stallreq_if_i,
  input  logic        stallreq_id_i,
  input  logic        stallreq_ex_i,
  input  logic        stallreq_mem_i,
  input  logic [3:0]  excp_type_i,
  input  logic [31:0] epc_i,
  output logic [5:0]  stall_o,
  output logic        flush_o,
  output logic [31:0] new_pc_o,
  output logic        timeout_o,
  output logic [31:0] stall_cycles_o,
  output logic [15:0] flush_count_o
);

  // state | meaning
  // RUN   | normal operation, stall vector follows the requests
  // FLUSH | single flush cycle, inputs ignored, stall forced to 0
  typedef enum logic {RUN, FLUSH} state_t;

  localparam logic [3:0]  EXCP_ERET = 4'hE;
  localparam logic [15:0] WDT_LOAD  = STALL_TIMEOUT - 16'd1;

  state_t      state;
  logic [5:0]  stall_req;
  logic [15:0] wdt_rem;
  logic        stalled;
  logic        flush_start;

  always_comb begin
    stall_req = ({6{stallreq_mem_i}} & 6'b011111)
              | ({6{stallreq_ex_i}}  & 6'b001111)
              | ({6{stallreq_id_i}}  & 6'b000111)
              | ({6{stallreq_if_i}}  & 6'b000011);
    stall_o   = (rst || state == FLUSH) ? 6'd0 : stall_req;
    stalled   = (stall_o != 6'd0);
  end

  // Any RUN -> FLUSH transition taken at the coming edge.
  assign flush_start = !rst && state == RUN &&
                       ((excp_type_i != 4'd0) || (stalled && wdt_rem == 16'd0));

  // Watchdog is a down-counter of remaining stalled cycles; terminal count 0 fires.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= RUN;
      flush_o   <= 1'b0;
      new_pc_o  <= 32'd0;
      timeout_o <= 1'b0;
      wdt_rem   <= WDT_LOAD;
    end else begin
      case (state)
        RUN: begin
          if (excp_type_i != 4'd0) begin
            state     <= FLUSH;
            flush_o   <= 1'b1;
            new_pc_o  <= (excp_type_i == EXCP_ERET) ? epc_i : EXC_BASE;
            timeout_o <= 1'b0;
            wdt_rem   <= WDT_LOAD;
          end else if (stalled && wdt_rem == 16'd0) begin
            state     <= FLUSH;
            flush_o   <= 1'b1;
            new_pc_o  <= WDT_VECTOR;
            timeout_o <= 1'b1;
            wdt_rem   <= WDT_LOAD;
          end else begin
            flush_o   <= 1'b0;
            timeout_o <= 1'b0;
            wdt_rem   <= stalled ? wdt_rem - 16'd1 : WDT_LOAD;
          end
        end
        FLUSH: begin
          state     <= RUN;
          flush_o   <= 1'b0;
          timeout_o <= 1'b0;
          wdt_rem   <= WDT_LOAD;
        end
        default: begin
          state     <= RUN;
          flush_o   <= 1'b0;
          timeout_o <= 1'b0;
          wdt_rem   <= WDT_LOAD;
        end
      endcase
    end
  end

`ifdef PIPE_PERF_CNT_EN
  logic [31:0] stall_cycles_q;
  logic [15:0] flush_count_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cycles_q <= 32'd0;
      flush_count_q  <= 16'd0;
    end else begin
      if (stall_o[0] && stall_cycles_q != 32'hFFFF_FFFF)
        stall_cycles_q <= stall_cycles_q + 32'd1;
      if (flush_start && flush_count_q != 16'hFFFF)
        flush_count_q <= flush_count_q + 16'd1;
    end
  end

  assign stall_cycles_o = stall_cycles_q;
  assign flush_count_o  = flush_count_q;
`else
  logic unused_flush_start;
  assign unused_flush_start = flush_start;
  assign stall_cycles_o     = 32'd0;
  assign flush_count_o      = 16'd0;
`endif

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Self-checking bench for pipeline_ctrl: stall-encoding vector table plus flush, ERET,
// watchdog, reset and perf-counter sequences, checked through an expectation queue.
module tb_pipeline_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        stallreq_if_i, stallreq_id_i, stallreq_ex_i, stallreq_mem_i;
  logic [3:0]  excp_type_i;
  logic [31:0] epc_i;
  logic [5:0]  stall_o;
  logic        flush_o;
  logic [31:0] new_pc_o;
  logic        timeout_o;
  logic [31:0] stall_cycles_o;
  logic [15:0] flush_count_o;

  int total = 0;
  int bad   = 0;

  typedef struct {
    string       name;
    logic [5:0]  stall;
    logic        flush;
    logic        tmo;
    logic        chk_pc;
    logic [31:0] pc;
  } exp_t;

  typedef struct {
    logic [3:0] req;   // {mem, ex, id, if}
    logic [5:0] stall;
  } vec_t;

  exp_t exp_q[$];
  vec_t vecs[10];

  pipeline_ctrl #(.STALL_TIMEOUT(16'd8)) dut (
    .clk(clk), .rst(rst),
    .stallreq_if_i(stallreq_if_i), .stallreq_id_i(stallreq_id_i),
    .stallreq_ex_i(stallreq_ex_i), .stallreq_mem_i(stallreq_mem_i),
    .excp_type_i(excp_type_i), .epc_i(epc_i),
    .stall_o(stall_o), .flush_o(flush_o), .new_pc_o(new_pc_o),
    .timeout_o(timeout_o), .stall_cycles_o(stall_cycles_o),
    .flush_count_o(flush_count_o)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input logic [3:0] r);
    {stallreq_mem_i, stallreq_ex_i, stallreq_id_i, stallreq_if_i} = r;
  endtask

  task automatic expect_out(input string name, input logic [5:0] s, input logic f,
                            input logic t, input logic cp, input logic [31:0] pc);
    exp_t e;
    e.name = name; e.stall = s; e.flush = f; e.tmo = t; e.chk_pc = cp; e.pc = pc;
    exp_q.push_back(e);
  endtask

  task automatic check();
    exp_t e;
    #1;
    if (exp_q.size() == 0) begin
      total++; bad++;
      $display("FAIL scoreboard_empty");
      return;
    end
    e = exp_q.pop_front();
    total++;
    if (stall_o !== e.stall || flush_o !== e.flush || timeout_o !== e.tmo ||
        (e.chk_pc && new_pc_o !== e.pc)) begin
      bad++;
      $display("FAIL %s: got stall=%b flush=%b tmo=%b pc=%h, want stall=%b flush=%b tmo=%b pc=%h",
               e.name, stall_o, flush_o, timeout_o, new_pc_o, e.stall, e.flush, e.tmo, e.pc);
    end
  endtask

  task automatic check_perf(input string name, input logic [31:0] sc, input logic [15:0] fc);
    total++;
    if (stall_cycles_o !== sc || flush_count_o !== fc) begin
      bad++;
      $display("FAIL %s: got stall_cycles=%0d flush_count=%0d, want %0d %0d",
               name, stall_cycles_o, flush_count_o, sc, fc);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
  endtask

  initial begin
    vecs[0] = '{4'b0000, 6'b000000};
    vecs[1] = '{4'b0001, 6'b000011};
    vecs[2] = '{4'b0010, 6'b000111};
    vecs[3] = '{4'b0100, 6'b001111};
    vecs[4] = '{4'b1000, 6'b011111};
    vecs[5] = '{4'b1010, 6'b011111};
    vecs[6] = '{4'b0011, 6'b000111};
    vecs[7] = '{4'b0101, 6'b001111};
    vecs[8] = '{4'b1111, 6'b011111};
    vecs[9] = '{4'b0110, 6'b001111};

    set_req(4'b0000); excp_type_i = 4'd0; epc_i = 32'd0;
    do_reset();
    expect_out("reset_state", 6'd0, 1'b0, 1'b0, 1'b1, 32'd0);
    check();
    check_perf("perf_reset", 32'd0, 16'd0);

    // Stall encoding table; requests drop each cycle so the watchdog never runs.
    for (int i = 0; i < 10; i++) begin
      set_req(vecs[i].req);
      expect_out($sformatf("stall_vec%0d", i), vecs[i].stall, 1'b0, 1'b0, 1'b0, 32'd0);
      check();
      set_req(4'b0000);
      step();
    end

    // Exception beats a concurrent EX stall.
    set_req(4'b0100); excp_type_i = 4'h3;
    expect_out("exc_pre_edge", 6'b001111, 1'b0, 1'b0, 1'b0, 32'd0);
    check();
    step();
    excp_type_i = 4'd0;
    expect_out("exc_flush", 6'd0, 1'b1, 1'b0, 1'b1, 32'h0000_0100);
    check();
    step();
    expect_out("exc_back_run", 6'b001111, 1'b0, 1'b0, 1'b0, 32'd0);
    check();
    set_req(4'b0000);
    step();

    // ERET, with a second exception presented during FLUSH that must be ignored.
    excp_type_i = 4'hE; epc_i = 32'h0000_2468;
    step();
    excp_type_i = 4'h5; epc_i = 32'h0000_9999;
    expect_out("eret_flush", 6'd0, 1'b1, 1'b0, 1'b1, 32'h0000_2468);
    check();
    step();
    excp_type_i = 4'd0;
    expect_out("eret_exc_ignored", 6'd0, 1'b0, 1'b0, 1'b1, 32'h0000_2468);
    check();
    step();
    expect_out("eret_no_reflush", 6'd0, 1'b0, 1'b0, 1'b0, 32'd0);
    check();

    // Watchdog with STALL_TIMEOUT=8: fires at the edge ending the 8th stalled cycle.
    do_reset();
    set_req(4'b1000);
    for (int i = 1; i <= 7; i++) begin
      step();
      expect_out($sformatf("wdt_hold%0d", i), 6'b011111, 1'b0, 1'b0, 1'b0, 32'd0);
      check();
    end
    step();
    expect_out("wdt_fire", 6'd0, 1'b1, 1'b1, 1'b1, 32'h0000_0120);
    check();
    step();
    expect_out("wdt_after", 6'b011111, 1'b0, 1'b0, 1'b0, 32'd0);
    check();

    // Seven stalled cycles then release: no timeout.
    do_reset();
    set_req(4'b1000);
    for (int i = 0; i < 7; i++) step();
    set_req(4'b0000);
    expect_out("wdt_seven_edge", 6'd0, 1'b0, 1'b0, 1'b0, 32'd0);
    check();
    for (int i = 0; i < 3; i++) step();
    expect_out("wdt_seven_none", 6'd0, 1'b0, 1'b0, 1'b0, 32'd0);
    check();

    // Reset during FLUSH.
    excp_type_i = 4'h2;
    step();
    excp_type_i = 4'd0;
    expect_out("rstf_flush", 6'd0, 1'b1, 1'b0, 1'b1, 32'h0000_0100);
    check();
    rst = 1'b1; set_req(4'b1111);
    expect_out("rstf_stall_zero", 6'd0, 1'b1, 1'b0, 1'b0, 32'd0);
    check();
    step();
    expect_out("rstf_cleared", 6'd0, 1'b0, 1'b0, 1'b1, 32'd0);
    check();
    rst = 1'b0; set_req(4'b0100);
    expect_out("rstf_run", 6'b001111, 1'b0, 1'b0, 1'b0, 32'd0);
    check();
    set_req(4'b0000);

    // Perf counters: 5 stalled cycles then one exception.
    do_reset();
    set_req(4'b1000);
    for (int i = 0; i < 5; i++) step();
    set_req(4'b0000); excp_type_i = 4'h3;
    step();
    excp_type_i = 4'd0;
    step();
`ifdef PIPE_PERF_CNT_EN
    check_perf("perf_counts", 32'd5, 16'd1);
`else
    check_perf("perf_counts_off", 32'd0, 16'd0);
`endif

    if (exp_q.size() != 0) begin
      total++; bad++;
      $display("FAIL scoreboard_leftover: %0d entries", exp_q.size());
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/pipeline_ctrl.md
# pipeline_ctrl

Central pipeline sequencer for the dual-issue core. It merges stall requests from the IF, ID, EX and MEM stages into the six-bit `stall` vector consumed by the PC register and the inter-stage latches. It also turns MEM-stage exceptions and ERET into a one-cycle pipeline flush with a redirect address, and breaks persistent stalls with a watchdog. It sits beside the PC register and drives its `stall` input, plus the flush/redirect path into fetch.

## Interface
- `EXC_BASE`, default 32'h0000_0100: handler address for all exceptions.
- `WDT_VECTOR`, default 32'h0000_0120: redirect address on watchdog timeout.
- `STALL_TIMEOUT`, default 16'd1024: consecutive stalled cycles that trigger the watchdog. Legal range is 2..65535.

Ports:
- `clk`  in  1  Clock.
- `rst`  in  1  Reset. Synchronous, active-high.
- `stallreq_if_i`  in  1  IF stage requests a stall.
- `stallreq_id_i`  in  1  ID stage requests a stall.
- `stallreq_ex_i`  in  1  EX stage requests a stall.
- `stallreq_mem_i`  in  1  MEM stage requests a stall.
- `excp_type_i`  in  4  MEM-stage event. 0 = none, 4'hE = ERET, any other nonzero value = exception.
- `epc_i`  in  32  Return address for ERET.
- `stall_o`  out  6  Stall vector. bit0 = PC, 1 = IF, 2 = ID, 3 = EX, 4 = MEM, 5 = WB.
- `flush_o`  out  1  Flush all pipeline latches. Registered.
- `new_pc_o`  out  32  Redirect target, valid while `flush_o` is high. Registered.
- `timeout_o`  out  1  One-cycle pulse when the watchdog fires.
- `stall_cycles_o`  out  32  Count of cycles with `stall_o[0]` set. Feature-gated.
- `flush_count_o`  out  16  Count of flushes issued. Feature-gated.

## Operation
- **FSM states:**
  - RUN: normal operation.
  - FLUSH: exactly one cycle.
- **Stall encoding (combinational, in RUN):**
  - A MEM request gives 6'b011111.
  - An EX request gives 6'b001111.
  - An ID request gives 6'b000111.
  - An IF request gives 6'b000011.
  - No request gives 0.
  - The deepest requesting stage wins, so the result is the OR of the individual patterns.
- **RUN → FLUSH:** taken when `excp_type_i != 0` is sampled at a clock edge.
  - ERET loads `new_pc_o` with `epc_i`.
  - Any other nonzero type loads `new_pc_o` with `EXC_BASE`.
  - `flush_o` is set to 1 at the same edge.
  - If an exception and stall requests occur in the same cycle, the exception wins.
- **In FLUSH:**
  - `stall_o` is forced to 0.
  - All inputs are ignored.
  - At the next edge the block clears `flush_o` and returns to RUN.
  - `new_pc_o` holds its value.
- **Watchdog:**
  - A 16-bit counter increments each RUN cycle in which `stall_o != 0`. It clears on any non-stalled cycle and on entry to FLUSH.
  - When the counter reaches `STALL_TIMEOUT - 1` with the stall still active, the next edge enters FLUSH with `new_pc_o = WDT_VECTOR`.
  - `timeout_o` pulses for one cycle together with that `flush_o`.
  - If a real exception occurs on that same edge, the exception has priority. `timeout_o` stays 0 and the counter clears.
- **Reset:** `rst` wins over everything, including mid-FLUSH.
  - State returns to RUN.
  - `flush_o` = 0, `new_pc_o` = 0, `timeout_o` = 0.
  - Watchdog counter = 0, and both perf counters = 0.
  - `stall_o` reads 0 while `rst` is high.

## Timing
- `stall_o` has zero latency: it is a same-cycle function of the stall requests and the FSM state.
- Flush latency is 1 cycle. An exception sampled at edge N gives `flush_o` high from N through N+1, and `new_pc_o` is valid in the same window.
- At most one flush every 2 cycles, because FLUSH is never back-to-back.
- The watchdog fires after `STALL_TIMEOUT` consecutive stalled cycles. `flush_o` rises at the edge that ends the final stalled cycle.

## Configuration
- Controlled by the macro `PIPE_PERF_CNT_EN`.
- **Defined:**
  - `stall_cycles_o` increments every cycle with `stall_o[0] == 1`. It saturates at 32'hFFFF_FFFF.
  - `flush_count_o` increments on each RUN → FLUSH transition. It saturates at 16'hFFFF.
  - Both counters clear only on reset.
- **Undefined:** both outputs are tied to 0 and no counter registers are synthesized.

## Test plan
- **Stall priority:** `stallreq_id_i`=1 and `stallreq_mem_i`=1 in the same cycle → `stall_o` = 6'b011111. Then only `stallreq_if_i`=1 → `stall_o` = 6'b000011.
- **Exception flush:** `excp_type_i`=4'h3 for one cycle while `stallreq_ex_i`=1 → at the next edge `flush_o`=1, `new_pc_o`=32'h100 and `stall_o`=0, each for one cycle. Then the block returns to RUN with `stall_o` = 6'b001111.
- **ERET:** `excp_type_i`=4'hE with `epc_i`=32'h0000_2468 → `flush_o`=1 and `new_pc_o`=32'h2468. A second exception applied during FLUSH is ignored.
- **Watchdog:** `STALL_TIMEOUT`=8 with `stallreq_mem_i` held high → after 8 stalled cycles `timeout_o` and `flush_o` pulse, and `new_pc_o`=32'h120. With `STALL_TIMEOUT`=8 and the stall dropped after 7 stalled cycles → no timeout.
- **Reset mid-flush:** `rst` asserted during the FLUSH cycle → at the next edge `flush_o`=0, `new_pc_o`=0 and the state is RUN. `stall_o` is 0 while `rst` is high.
- **Perf counters (macro defined):** 5 stalled cycles followed by 1 exception → `stall_cycles_o`=5 and `flush_count_o`=1. With the macro undefined, both outputs stay 0.
